cordic_rr_arbiter: RTL
======================

CORDIC_RR_ARBITER -- requirements
Module: cordic_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 32, angle/result width.
REQ-003 Parameter DEPTH, default 16, tag FIFO depth (power of 2) = max outstanding CORDIC operations.
REQ-004 The block SHALL use reset reset, asynchronous, active-low; clock clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester angle valid.
REQ-008 req_theta  in  NREQ*W  packed angles; requester i at bits [i*W +: W].
REQ-009 req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-010 cordic_wr_en  out  1  push to CORDIC input FIFO.
REQ-011 cordic_theta  out  W  angle to CORDIC input FIFO.
REQ-012 cordic_full  in  1  CORDIC input FIFO full.
REQ-013 cordic_rd_en  out  1  pop CORDIC output FIFOs (first-word-fall-through).
REQ-014 cordic_cos, cordic_sin  in  W each  CORDIC output FIFO heads.
REQ-015 cordic_empty  in  1  CORDIC output FIFOs empty.
REQ-016 rsp_valid  out  NREQ  one-hot response valid to owning requester.
REQ-017 rsp_cos, rsp_sin  out  W each  registered result.
REQ-018 rsp_ready  in  NREQ  per-requester response accept.
REQ-019 err_orphan  out  1  sticky: CORDIC result arrived with no outstanding tag.

Function
REQ-020 Issue allowed in a cycle only when cordic_full==0 and tag FIFO not full (push blocked at full even if a pop occurs that cycle).
REQ-021 When allowed, req_ready SHALL be asserted combinationally for the first requester with req_valid set, searching from rr_ptr upward modulo NREQ; at most one bit set.
REQ-022 On a grant to i: cordic_wr_en=1, cordic_theta=req_theta[i], tag i pushed to tag FIFO, rr_ptr <= (i+1) mod NREQ at the clock edge.
REQ-023 No grant -> cordic_wr_en=0, rr_ptr unchanged.
REQ-024 Response register loads when cordic_empty==0, tag FIFO non-empty, and register empty or being consumed this cycle; load asserts cordic_rd_en, pops tag, sets rsp_valid=onehot(tag), captures cos/sin.
REQ-025 Register consumed when rsp_valid[t] & rsp_ready[t]; consume and reload in same cycle SHALL sustain 1 result/cycle.
REQ-026 rsp_valid, rsp_cos, rsp_sin SHALL hold stable until consumed.
REQ-027 cordic_empty==0 with tag FIFO empty: err_orphan set, cordic_rd_en=1 (result discarded), no rsp_valid.
REQ-028 Simultaneous tag push and pop when neither full nor empty: occupancy unchanged, both succeed.
REQ-029 Results return to requesters in issue order; requesters not backpressured by other requesters' outstanding results except via full tag FIFO.

Reset
REQ-030 On reset low: rr_ptr=0, tag FIFO empty, rsp_valid=0, rsp_cos=rsp_sin=0, err_orphan=0, cordic_wr_en=0, cordic_rd_en=0, req_ready=0, effective immediately and mid-operation.
REQ-031 In-flight tags are discarded by reset; err_orphan clears only by reset.

Configuration
REQ-032 Macro CORDIC_ARB_CNT_EN defined: adds output grant_cnt (NREQ*16) holding per-requester 16-bit wrapping grant counters, reset 0, incremented on each grant.
REQ-033 Macro undefined: grant_cnt port and counters absent; all other behaviour identical.

Verification
REQ-034 All 4 valid, no backpressure, 8 cycles -> grants 0,1,2,3,0,1,2,3; cordic_theta matches granted angle.
REQ-035 Requester 2 only, theta=0x3243F6A8 -> req_ready=4'b0100 same cycle; on result, rsp_valid=4'b0100 with CORDIC cos/sin.
REQ-036 Issue 16 ops with CORDIC output held empty -> 17th request sees req_ready=0 until one result popped.
REQ-037 rsp_ready low for 5 cycles with results queued -> rsp held stable, cordic_rd_en=0, no loss; releasing gives 1 result/cycle.
REQ-038 cordic_empty driven low with no issued ops -> err_orphan=1 next cycle, rsp_valid stays 0.
REQ-039 Reset asserted with 3 outstanding -> all outputs 0 immediately; after release first grant goes to requester 0.

Source files
------------

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter feeding a shared CORDIC, routing results back to the issuing requester in issue order.
// Optional CORDIC_ARB_CNT_EN adds per-requester 16-bit grant counters on grant_cnt.
module cordic_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_theta,
  output logic [NREQ-1:0]   req_ready,
  output logic              cordic_wr_en,
  output logic [W-1:0]      cordic_theta,
  input  logic              cordic_full,
  output logic              cordic_rd_en,
  input  logic [W-1:0]      cordic_cos,
  input  logic [W-1:0]      cordic_sin,
  input  logic              cordic_empty,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_cos,
  output logic [W-1:0]      rsp_sin,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              err_orphan
`ifdef CORDIC_ARB_CNT_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int TW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);

  logic [TW-1:0]   r_rr_ptr;
  logic [TW-1:0]   r_tag_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [NREQ-1:0] r_rsp_valid;
  logic [W-1:0]    r_rsp_cos;
  logic [W-1:0]    r_rsp_sin;
  logic            r_err_orphan;

  logic            w_tag_full;
  logic            w_tag_empty;
  logic            w_issue_ok;
  logic            w_found;
  logic [TW:0]     w_cand;
  logic [TW-1:0]   w_gnt_idx;
  logic [TW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_grant;
  logic            w_push;
  logic            w_consume;
  logic            w_load;
  logic            w_orphan;
  logic [TW-1:0]   w_tag_head;

  assign w_tag_full  = (r_count == (AW+1)'(DEPTH));
  assign w_tag_empty = (r_count == '0);
  // Reset gates every combinational output so they drop the instant reset asserts.
  assign w_issue_ok  = reset && !cordic_full && !w_tag_full;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_grant   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (TW+1)'(k);
      if (w_cand >= (TW+1)'(NREQ)) w_cand = w_cand - (TW+1)'(NREQ);
      if (!w_found && req_valid[w_cand[TW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[TW-1:0];
      end
    end
    if (!w_issue_ok) w_found = 1'b0;
    if (w_found) w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_push       = w_found;
  assign w_ptr_nxt    = (w_gnt_idx == TW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
  assign req_ready    = w_grant;
  assign cordic_wr_en = w_push;
  assign cordic_theta = req_theta[int'(w_gnt_idx)*W +: W];

  assign w_tag_head   = r_tag_mem[r_rd_ptr];
  assign w_consume    = |(r_rsp_valid & rsp_ready);
  assign w_load       = reset && !cordic_empty && !w_tag_empty && (!(|r_rsp_valid) || w_consume);
  assign w_orphan     = reset && !cordic_empty && w_tag_empty;
  assign cordic_rd_en = w_load || w_orphan;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_cos    = r_rsp_cos;
  assign rsp_sin    = r_rsp_sin;
  assign err_orphan = r_err_orphan;

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= w_gnt_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_cos    <= '0;
      r_rsp_sin    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_rsp_valid <= NREQ'(1) << w_tag_head;
        r_rsp_cos   <= cordic_cos;
        r_rsp_sin   <= cordic_sin;
      end else if (w_consume) begin
        r_rsp_valid <= '0;
      end
      if (w_orphan) r_err_orphan <= 1'b1;
    end
  end

`ifdef CORDIC_ARB_CNT_EN
  logic [NREQ*16-1:0] r_grant_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_cnt <= '0;
    end else if (w_push) begin
      r_grant_cnt[int'(w_gnt_idx)*16 +: 16] <= r_grant_cnt[int'(w_gnt_idx)*16 +: 16] + 16'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule
